envelope_shaper: RTL and testbench
==================================

Name: envelope_shaper

Overview:
- Sits directly downstream of the sample generator; consumes its 12-bit signed outSample and applies an ADSR amplitude envelope.
- Produces the note-shaped 12-bit signed sample for the DAC output stage.
- Envelope advances once per sample-rate tick (inSampleEnable).
- Gate comes from the MIDI note handler.

Parameters:
- SAMPLE_W, 12, signed sample width in and out.
- LEVEL_W, 16, unsigned envelope level width; full scale = 2^LEVEL_W-1.

Ports:
- inCLK  input  1  system clock.
- inRESET  input  1  synchronous, active-high reset.
- inSampleEnable  input  1  one-cycle pulse at sample rate; all envelope and output updates happen only on cycles where it is high.
- inGate  input  1  note held (1) / released (0).
- inSample  input  SAMPLE_W  signed raw sample from the sample generator.
- inAttackStep  input  LEVEL_W  level increment per tick in ATTACK; 0 = instantaneous.
- inDecayStep  input  LEVEL_W  level decrement per tick in DECAY; 0 = instantaneous.
- inSustainLevel  input  8  sustain target; 16-bit equivalent is {inSustainLevel, 8'h00}.
- inReleaseStep  input  LEVEL_W  level decrement per tick in RELEASE; 0 = instantaneous.
- outSample  output  SAMPLE_W  signed enveloped sample, registered.
- outActive  output  1  high when state != IDLE.
- outLevel  output  LEVEL_W  current envelope level, registered.

Behaviour:
- Reset (synchronous, inRESET=1 at posedge inCLK):
  - state=IDLE, level=0, outSample=0, outActive=0.
  - Reset overrides everything, including a coincident tick. Reset mid-note aborts to IDLE immediately.
- No tick cycle: all registers hold.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Evaluated only on tick cycles. Gate is sampled only at ticks; pulses between ticks are ignored.
- Gate priority, checked first on each tick:
  - inGate=1 in IDLE or RELEASE -> ATTACK. Level is not cleared (retrigger from current level).
  - inGate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE. Level is unchanged on this tick.
- ATTACK: if step==0 or level+step >= 0xFFFF -> level=0xFFFF, state DECAY. Else level+=step.
- DECAY (S = {inSustainLevel,8'h00}):
  - If step==0 or level <= S+step -> level=S, state SUSTAIN. Else level-=step.
  - If S is raised above level mid-decay, level jumps to S the same tick.
- SUSTAIN: level=S every tick, so it tracks live sustain changes.
- RELEASE: if step==0 or level <= step -> level=0, state IDLE. Else level-=step.
- Arithmetic:
  - Compute with LEVEL_W+1 bits to avoid wrap; no overflow or underflow wrap is allowed.
  - Gain g = level[15:4], treated as 13-bit signed {1'b0, g}.
  - product = inSample * g, 25-bit signed.
  - outSample = product[23:12], arithmetic truncation toward -inf.
  - Range is always [-2048, 2046], so there is no overflow.
- Latency:
  - On a tick, outSample is computed from the inSample present at that tick and the level before that tick's update.
  - It is visible the cycle after the tick.
  - outLevel and outActive show the post-update values, also visible the cycle after the tick.
- IDLE: level=0, so outSample=0 on every tick.

Decomposition:
- Package synth_pkg holds: SAMPLE_W, LEVEL_W, LEVEL_MAX (16'hFFFF), and the ADSR state enum encoding (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4, 3 bits).
- Sub-module adsr_core holds the state machine and level register, with inputs tick, gate, steps and sustain, and outputs level and active.
- envelope_shaper instantiates adsr_core and holds the multiply and output register.

Test Plan:
- Reset:
  - Drive inRESET=1 with ticks and gate=1 -> outSample=0, outLevel=0, outActive=0 throughout.
  - Release reset and hold gate=0 with ticks -> stays IDLE, outSample=0.
- Attack and decay:
  - Setup: inAttackStep=0x4000, inDecayStep=0x1000, inSustainLevel=0x80, gate=1, inSample=0x7FF.
  - Attack: outLevel goes 0x4000, 0x8000, 0xC000, 0xFFFF at ticks 1-4.
  - Decay: 0xEFFF, ... down to 0x8000, then SUSTAIN.
  - outSample at full level = 0x7FE (2046).
- Release:
  - From SUSTAIN at 0x8000, drop gate with inReleaseStep=0x3000.
  - First tick: level 0x8000, state RELEASE.
  - Then 0x5000, 0x2000, then 0 with outActive=0 on the following tick.
- Retrigger:
  - Reassert gate while in RELEASE at level 0x2000, attack step 0x4000 -> next tick ATTACK, following tick level 0x6000 (not from 0).
- Instantaneous and negative:
  - All steps=0, sustain=0xFF, inSample=0x800, gate=1.
  - Sequence: ATTACK -> level 0xFFFF -> SUSTAIN at 0xFF00.
  - outSample = (-2048*0xFF0)>>12 = -2040 = 12'h808.
- Boundary: assert tick and inRESET together mid-note -> reset wins, state IDLE; no tick for 100 cycles -> outputs hold bit-exact.

Source files
------------

// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared constants for the synthesizer voice path: sample and envelope widths,
// the envelope full-scale value and the ADSR state encoding. Also provides a
// helper that expands the 8-bit sustain setting to a full envelope level.
// -----------------------------------------------------------------------------
package synth_pkg;

  localparam int SAMPLE_W = 12;
  localparam int LEVEL_W  = 16;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 16'hFFFF;

  // ADSR state encoding, kept as plain constants so older tools can read it.
  typedef logic [2:0] adsr_state_t;
  localparam adsr_state_t ST_IDLE    = 3'd0;
  localparam adsr_state_t ST_ATTACK  = 3'd1;
  localparam adsr_state_t ST_DECAY   = 3'd2;
  localparam adsr_state_t ST_SUSTAIN = 3'd3;
  localparam adsr_state_t ST_RELEASE = 3'd4;

  // Sustain is specified in 1/256 steps of full scale; the low byte is zero.
  function automatic logic [LEVEL_W-1:0] sustain_to_level(input logic [7:0] sus);
    return {sus, 8'h00};
  endfunction

endpackage

// File: rtl/adsr_core.sv
// -----------------------------------------------------------------------------
// adsr_core
// ADSR envelope state machine and level register. Advances only on tick_i.
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   tick_i         sample-rate enable pulse
//   gate_i         note held (1) / released (0), sampled on ticks only
//   attack_step_i  level increment per tick in ATTACK (0 = instantaneous)
//   decay_step_i   level decrement per tick in DECAY (0 = instantaneous)
//   sustain_i      sustain target, upper byte of the 16-bit level
//   release_step_i level decrement per tick in RELEASE (0 = instantaneous)
//   level_o        current envelope level (registered)
//   active_o       high whenever the state is not IDLE (registered)
// -----------------------------------------------------------------------------
module adsr_core
  import synth_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               gate_i,
  input  logic [LEVEL_W-1:0] attack_step_i,
  input  logic [LEVEL_W-1:0] decay_step_i,
  input  logic [7:0]         sustain_i,
  input  logic [LEVEL_W-1:0] release_step_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic               active_o
);

  adsr_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               active_q, active_d;

  logic [LEVEL_W-1:0] sustain_lvl_s;
  // One extra bit so additions near full scale never wrap.
  logic [LEVEL_W:0]   attack_sum_s;
  logic [LEVEL_W:0]   decay_thr_s;

  assign sustain_lvl_s = sustain_to_level(sustain_i);
  assign attack_sum_s  = {1'b0, level_q} + {1'b0, attack_step_i};
  assign decay_thr_s   = {1'b0, sustain_lvl_s} + {1'b0, decay_step_i};

  // Next-state and next-level decode; gate changes take priority over stepping.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    active_d = active_q;
    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (gate_i) begin
            state_d = ST_ATTACK;
          end else begin
            level_d = {LEVEL_W{1'b0}};
          end
        end
        ST_ATTACK: begin
          if (!gate_i) begin
            state_d = ST_RELEASE;
          end else if ((attack_step_i == 16'h0000) ||
                       (attack_sum_s >= {1'b0, LEVEL_MAX})) begin
            level_d = LEVEL_MAX;
            state_d = ST_DECAY;
          end else begin
            level_d = attack_sum_s[LEVEL_W-1:0];
          end
        end
        ST_DECAY: begin
          // The threshold test also covers sustain being raised above level.
          if (!gate_i) begin
            state_d = ST_RELEASE;
          end else if ((decay_step_i == 16'h0000) ||
                       ({1'b0, level_q} <= decay_thr_s)) begin
            level_d = sustain_lvl_s;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - decay_step_i;
          end
        end
        ST_SUSTAIN: begin
          if (!gate_i) begin
            state_d = ST_RELEASE;
          end else begin
            level_d = sustain_lvl_s;
          end
        end
        ST_RELEASE: begin
          if (gate_i) begin
            state_d = ST_ATTACK;
          end else if ((release_step_i == 16'h0000) ||
                       (level_q <= release_step_i)) begin
            level_d = {LEVEL_W{1'b0}};
            state_d = ST_IDLE;
          end else begin
            level_d = level_q - release_step_i;
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = {LEVEL_W{1'b0}};
        end
      endcase
      active_d = (state_d != ST_IDLE);
    end else begin
      active_d = active_q;
    end
  end

  // State, level and activity registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      level_q  <= {LEVEL_W{1'b0}};
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      active_q <= active_d;
    end
  end

  assign level_o  = level_q;
  assign active_o = active_q;

endmodule

// File: rtl/envelope_shaper.sv
// -----------------------------------------------------------------------------
// envelope_shaper
// Applies an ADSR amplitude envelope to the signed sample stream.
//   inCLK           system clock
//   inRESET         synchronous active-high reset
//   inSampleEnable  sample-rate pulse; all updates happen only when high
//   inGate          note held / released
//   inSample        signed raw sample
//   inAttackStep, inDecayStep, inReleaseStep  per-tick level steps
//   inSustainLevel  sustain target (upper byte of level)
//   outSample       enveloped signed sample (registered)
//   outActive       envelope not IDLE (registered)
//   outLevel        current envelope level (registered)
// -----------------------------------------------------------------------------
module envelope_shaper
  import synth_pkg::*;
(
  input  logic                       inCLK,
  input  logic                       inRESET,
  input  logic                       inSampleEnable,
  input  logic                       inGate,
  input  logic signed [SAMPLE_W-1:0] inSample,
  input  logic        [LEVEL_W-1:0]  inAttackStep,
  input  logic        [LEVEL_W-1:0]  inDecayStep,
  input  logic        [7:0]          inSustainLevel,
  input  logic        [LEVEL_W-1:0]  inReleaseStep,
  output logic signed [SAMPLE_W-1:0] outSample,
  output logic                       outActive,
  output logic        [LEVEL_W-1:0]  outLevel
);

  localparam int GAIN_W = LEVEL_W - 4;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic [LEVEL_W-1:0]         level_s;
  logic                       active_s;
  logic [GAIN_W-1:0]          gain_s;
  logic [PROD_W-1:0]          sample_ext_s;
  logic [PROD_W-1:0]          gain_ext_s;
  logic signed [PROD_W-1:0]   product_s;
  logic signed [SAMPLE_W-1:0] sample_d;
  logic signed [SAMPLE_W-1:0] sample_q;

  adsr_core u_adsr_core (
    .clk_i          (inCLK),
    .rst_i          (inRESET),
    .tick_i         (inSampleEnable),
    .gate_i         (inGate),
    .attack_step_i  (inAttackStep),
    .decay_step_i   (inDecayStep),
    .sustain_i      (inSustainLevel),
    .release_step_i (inReleaseStep),
    .level_o        (level_s),
    .active_o       (active_s)
  );

  // Gain is the top 12 bits of the pre-update level, used as a positive value.
  assign gain_s       = GAIN_W'(level_s >> 4);
  assign sample_ext_s = {{(PROD_W-SAMPLE_W){inSample[SAMPLE_W-1]}}, inSample};
  assign gain_ext_s   = {{(PROD_W-GAIN_W){1'b0}}, gain_s};
  assign product_s    = $signed(sample_ext_s) * $signed(gain_ext_s);
  // Arithmetic shift floors toward -inf; the result always fits in SAMPLE_W.
  assign sample_d     = SAMPLE_W'(product_s >>> 12);

  // Output sample register, updated only on sample ticks.
  always_ff @(posedge inCLK) begin
    if (inRESET) begin
      sample_q <= {SAMPLE_W{1'b0}};
    end else if (inSampleEnable) begin
      sample_q <= sample_d;
    end else begin
      sample_q <= sample_q;
    end
  end

  assign outSample = sample_q;
  assign outLevel  = level_s;
  assign outActive = active_s;

endmodule

// File: tb/tb_envelope_shaper.sv
module tb_envelope_shaper;

  logic        inCLK = 1'b0;
  logic        inRESET = 1'b1;
  logic        inSampleEnable = 1'b0;
  logic        inGate = 1'b0;
  logic [11:0] inSample = 12'h000;
  logic [15:0] inAttackStep = 16'h0000;
  logic [15:0] inDecayStep = 16'h0000;
  logic [7:0]  inSustainLevel = 8'h00;
  logic [15:0] inReleaseStep = 16'h0000;
  logic [11:0] outSample;
  logic        outActive;
  logic [15:0] outLevel;

  envelope_shaper dut (
    .inCLK          (inCLK),
    .inRESET        (inRESET),
    .inSampleEnable (inSampleEnable),
    .inGate         (inGate),
    .inSample       (inSample),
    .inAttackStep   (inAttackStep),
    .inDecayStep    (inDecayStep),
    .inSustainLevel (inSustainLevel),
    .inReleaseStep  (inReleaseStep),
    .outSample      (outSample),
    .outActive      (outActive),
    .outLevel       (outLevel)
  );

  always #5 inCLK = ~inCLK;

  typedef struct packed {
    logic [11:0] s;
    logic [15:0] l;
    logic        a;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference envelope model (spec arithmetic on plain integers)
  int m_state = 0;
  int m_level = 0;
  int m_out   = 0;

  task automatic model_tick(input logic rst, input logic gate, input logic [11:0] smp);
    int   p;
    int   s_lvl;
    exp_t e;
    if (rst) begin
      m_state = 0; m_level = 0; m_out = 0;
    end else begin
      p = $signed(smp) * (m_level / 16);
      m_out = p >>> 12;
      s_lvl = int'(inSustainLevel) * 256;
      case (m_state)
        0: if (gate) m_state = 1;
        1: if (!gate) m_state = 4;
           else if (inAttackStep == 16'h0000 || m_level + int'(inAttackStep) >= 65535) begin
             m_level = 65535; m_state = 2;
           end else m_level = m_level + int'(inAttackStep);
        2: if (!gate) m_state = 4;
           else if (inDecayStep == 16'h0000 || m_level <= s_lvl + int'(inDecayStep)) begin
             m_level = s_lvl; m_state = 3;
           end else m_level = m_level - int'(inDecayStep);
        3: if (!gate) m_state = 4; else m_level = s_lvl;
        4: if (gate) m_state = 1;
           else if (inReleaseStep == 16'h0000 || m_level <= int'(inReleaseStep)) begin
             m_level = 0; m_state = 0;
           end else m_level = m_level - int'(inReleaseStep);
        default: m_state = 0;
      endcase
    end
    e.s = m_out[11:0];
    e.l = m_level[15:0];
    e.a = (m_state != 0);
    sb_q.push_back(e);
  endtask

  task automatic cmp3(input string tag, input exp_t e);
    vectors++;
    assert (outSample === e.s) else begin
      miscompares++;
      $error("FAIL %s outSample: observed %h expected %h", tag, outSample, e.s);
    end
    vectors++;
    assert (outLevel === e.l) else begin
      miscompares++;
      $error("FAIL %s outLevel: observed %h expected %h", tag, outLevel, e.l);
    end
    vectors++;
    assert (outActive === e.a) else begin
      miscompares++;
      $error("FAIL %s outActive: observed %b expected %b", tag, outActive, e.a);
    end
  endtask

  // One tick cycle: drive, predict, clock, then pop and compare
  task automatic do_tick(input string tag, input logic gate, input logic [11:0] smp, input logic rst);
    inGate = gate; inSample = smp; inRESET = rst; inSampleEnable = 1'b1;
    model_tick(rst, gate, smp);
    @(posedge inCLK); #1;
    inSampleEnable = 1'b0; inRESET = 1'b0;
    if (sb_q.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
    end else begin
      last_e = sb_q.pop_front();
      cmp3(tag, last_e);
    end
  endtask

  task automatic chk_lvl(input string tag, input logic [15:0] exp_l);
    vectors++;
    assert (outLevel === exp_l) else begin
      miscompares++;
      $error("FAIL %s level: observed %h expected %h", tag, outLevel, exp_l);
    end
  endtask

  task automatic chk_smp(input string tag, input logic [11:0] exp_s);
    vectors++;
    assert (outSample === exp_s) else begin
      miscompares++;
      $error("FAIL %s sample: observed %h expected %h", tag, outSample, exp_s);
    end
  endtask

  task automatic chk_act(input string tag, input logic exp_a);
    vectors++;
    assert (outActive === exp_a) else begin
      miscompares++;
      $error("FAIL %s active: observed %b expected %b", tag, outActive, exp_a);
    end
  endtask

  // Non-tick cycles with noisy gate/sample: outputs must hold the last values
  task automatic hold_cycles(input string tag, input int n, input logic gate_after);
    for (int i = 0; i < n; i++) begin
      inGate = 1'($urandom_range(0, 1));
      inSample = 12'($urandom);
      @(posedge inCLK); #1;
      cmp3(tag, last_e);
    end
    inGate = gate_after;
  endtask

  logic [15:0] atk_lv [4];

  initial begin
    atk_lv[0] = 16'h4000; atk_lv[1] = 16'h8000; atk_lv[2] = 16'hC000; atk_lv[3] = 16'hFFFF;
    #2;
    // Reset held with ticks and gate high
    for (int i = 0; i < 3; i++) do_tick("reset", 1'b1, 12'h7FF, 1'b1);
    // Idle with gate low
    for (int i = 0; i < 3; i++) do_tick("idle", 1'b0, 12'h7FF, 1'b0);

    // Attack and decay
    inAttackStep = 16'h4000; inDecayStep = 16'h1000; inSustainLevel = 8'h80;
    do_tick("gate_on", 1'b1, 12'h7FF, 1'b0);
    chk_lvl("gate_on", 16'h0000);
    for (int i = 0; i < 4; i++) begin
      do_tick("attack", 1'b1, 12'h7FF, 1'b0);
      chk_lvl("attack", atk_lv[i]);
    end
    do_tick("decay0", 1'b1, 12'h7FF, 1'b0);
    chk_lvl("decay0", 16'hEFFF);
    chk_smp("full_scale", 12'h7FE);
    for (int i = 0; i < 7; i++) do_tick("decay", 1'b1, 12'h7FF, 1'b0);
    chk_lvl("sustain", 16'h8000);

    // Sustain tracks live changes; gate pulses between ticks are ignored
    inSustainLevel = 8'h90;
    do_tick("sus_up", 1'b1, 12'h400, 1'b0);
    chk_lvl("sus_up", 16'h9000);
    inSustainLevel = 8'h80;
    do_tick("sus_dn", 1'b1, 12'hC00, 1'b0);
    hold_cycles("gate_glitch", 5, 1'b1);
    do_tick("sus_hold", 1'b1, 12'h123, 1'b0);
    chk_lvl("sus_hold", 16'h8000);

    // Release to idle
    inReleaseStep = 16'h3000;
    do_tick("rel0", 1'b0, 12'h7FF, 1'b0);
    chk_lvl("rel0", 16'h8000);
    do_tick("rel1", 1'b0, 12'h7FF, 1'b0);
    chk_lvl("rel1", 16'h5000);
    do_tick("rel2", 1'b0, 12'h7FF, 1'b0);
    chk_lvl("rel2", 16'h2000);
    do_tick("rel3", 1'b0, 12'h7FF, 1'b0);
    chk_lvl("rel3", 16'h0000);
    chk_act("rel3", 1'b0);

    // Retrigger from release
    for (int i = 0; i < 13; i++) do_tick("note2", 1'b1, 12'h9A5, 1'b0);
    chk_lvl("note2_sus", 16'h8000);
    for (int i = 0; i < 3; i++) do_tick("note2_rel", 1'b0, 12'h3C1, 1'b0);
    chk_lvl("note2_rel", 16'h2000);
    do_tick("retrig0", 1'b1, 12'h7FF, 1'b0);
    chk_lvl("retrig0", 16'h2000);
    do_tick("retrig1", 1'b1, 12'h7FF, 1'b0);
    chk_lvl("retrig1", 16'h6000);

    // Reset coincident with tick mid-note
    do_tick("rst_tick", 1'b1, 12'h7FF, 1'b1);
    chk_act("rst_tick", 1'b0);

    // Instantaneous steps with negative full-scale sample
    inAttackStep = 16'h0000; inDecayStep = 16'h0000; inReleaseStep = 16'h0000;
    inSustainLevel = 8'hFF;
    do_tick("inst0", 1'b1, 12'h800, 1'b0);
    do_tick("inst1", 1'b1, 12'h800, 1'b0);
    chk_lvl("inst_attack", 16'hFFFF);
    do_tick("inst2", 1'b1, 12'h800, 1'b0);
    chk_lvl("inst_sustain", 16'hFF00);
    do_tick("inst3", 1'b1, 12'h800, 1'b0);
    chk_smp("neg_sample", 12'h808);

    // No ticks for 100 cycles: bit-exact hold
    hold_cycles("hold100", 100, 1'b1);

    // Instantaneous release
    do_tick("inst_rel", 1'b0, 12'h800, 1'b0);
    do_tick("inst_rel2", 1'b0, 12'h800, 1'b0);
    chk_lvl("inst_rel2", 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
